// File: rtl/wb_dma_arbiter.sv
// Purpose : shares the system Wishbone bus between the CPU (default owner) and NDMA DMA masters.
// Latency : a request sampled with the CPU idle and its slot used up drops cpu_gnt_o one edge later
//           and raises dma_gnt_o one edge after that. All outputs are registered.
// Backpressure: the CPU is held off via cpu_gnt_o. A DMA master keeps the bus until it drops req and cyc,
//           or it is revoked by the hold watchdog at a cyc-idle edge.
// Ports: wb_clk_i/wb_rst_i clock and sync active-high reset; cpu_cyc_i/cpu_gnt_o CPU cycle and grant;
//        dma_req_i/dma_cyc_i/dma_gnt_o per-master request, cycle and one-hot grant;
//        owner_o bus-mux select (0 = CPU, k+1 = DMA k); tmo_o one-cycle watchdog revoke pulse.
module wb_dma_arbiter #(
    parameter int NDMA     = 4,
    parameter int CPU_SLOT = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cpu_cyc_i,
    output logic            cpu_gnt_o,
    input  logic [NDMA-1:0] dma_req_i,
    input  logic [NDMA-1:0] dma_cyc_i,
    output logic [NDMA-1:0] dma_gnt_o,
    output logic [2:0]      owner_o,
    output logic            tmo_o
);

    localparam int PW = (NDMA > 1) ? $clog2(NDMA) : 1;
    localparam logic [7:0] SLOT_MAX = 8'(CPU_SLOT);
    localparam logic [7:0] TMO_MAX  = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_CPU,
        ST_DRAIN,
        ST_DMA,
        ST_DEAD
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   cur_q, cur_d;
    logic [7:0]      slot_cnt_q, slot_cnt_d;
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    logic            cpu_gnt_d;
    logic [NDMA-1:0] dma_gnt_d;
    logic [2:0]      owner_d;
    logic            tmo_d;

    logic            win_vld;
    logic [PW-1:0]   win_idx;
    logic            do_grant;
    logic            sel_req;
    logic            sel_cyc;
    logic            rel;
    logic            rvk;

    // Round-robin pick: scan downward so the last hit is the one closest
    // to rr_ptr (smallest offset), wrapping modulo NDMA.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NDMA - 1; i >= 0; i--) begin
            if (dma_req_i[(int'(rr_ptr_q) + i) % NDMA]) begin
                win_vld = 1'b1;
                win_idx = PW'((int'(rr_ptr_q) + i) % NDMA);
            end
        end
    end

    assign sel_req = dma_req_i[cur_q];
    assign sel_cyc = dma_cyc_i[cur_q];
    // Release takes precedence so a master that finishes on the timeout
    // edge is not flagged as revoked.
    assign rel = !sel_req && !sel_cyc;
    assign rvk = (hold_cnt_q == TMO_MAX) && !sel_cyc;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cur_d      = cur_q;
        slot_cnt_d = slot_cnt_q;
        hold_cnt_d = hold_cnt_q;
        cpu_gnt_d  = cpu_gnt_o;
        dma_gnt_d  = dma_gnt_o;
        owner_d    = owner_o;
        tmo_d      = 1'b0;
        do_grant   = 1'b0;

        case (state_q)
            ST_CPU: begin
                if (slot_cnt_q != SLOT_MAX) begin
                    slot_cnt_d = slot_cnt_q + 8'd1;
                end
                if (|dma_req_i && slot_cnt_q == SLOT_MAX) begin
                    cpu_gnt_d = 1'b0;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A CPU cycle already in flight is allowed to finish.
                if (!cpu_cyc_i) begin
                    if (win_vld) begin
                        do_grant = 1'b1;
                    end else begin
                        cpu_gnt_d = 1'b1;
                        state_d   = ST_CPU;
                    end
                end
            end
            ST_DMA: begin
                if (hold_cnt_q != TMO_MAX) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
                if (rel || rvk) begin
                    dma_gnt_d = '0;
                    owner_d   = 3'd0;
                    rr_ptr_d  = (int'(cur_q) == NDMA - 1) ? '0 : cur_q + PW'(1);
                    tmo_d     = !rel;
                    state_d   = ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (CPU_SLOT == 0 && win_vld) begin
                    do_grant = 1'b1;
                end else begin
                    cpu_gnt_d  = 1'b1;
                    owner_d    = 3'd0;
                    slot_cnt_d = 8'd0;
                    state_d    = ST_CPU;
                end
            end
            default: begin
                state_d = ST_CPU;
            end
        endcase

        if (do_grant) begin
            dma_gnt_d  = NDMA'(1) << win_idx;
            owner_d    = 3'(win_idx) + 3'd1;
            cur_d      = win_idx;
            hold_cnt_d = 8'd0;
            state_d    = ST_DMA;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_CPU;
            rr_ptr_q   <= '0;
            cur_q      <= '0;
            slot_cnt_q <= 8'd0;
            hold_cnt_q <= 8'd0;
            cpu_gnt_o  <= 1'b1;
            dma_gnt_o  <= '0;
            owner_o    <= 3'd0;
            tmo_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_q      <= cur_d;
            slot_cnt_q <= slot_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            cpu_gnt_o  <= cpu_gnt_d;
            dma_gnt_o  <= dma_gnt_d;
            owner_o    <= owner_d;
            tmo_o      <= tmo_d;
        end
    end

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Purpose : directed bench for wb_dma_arbiter (default instance plus a TIMEOUT=8 instance).
// Latency : stimulus driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: n/a; masters are modelled by directly driving req/cyc.
module tb_wb_dma_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_cyc;
    logic       cpu_gnt;
    logic [3:0] dma_req;
    logic [3:0] dma_cyc;
    logic [3:0] dma_gnt;
    logic [2:0] owner;
    logic       tmo;

    logic       t_cpu_gnt;
    logic [3:0] t_req;
    logic [3:0] t_cyc;
    logic [3:0] t_gnt;
    logic [2:0] t_owner;
    logic       t_tmo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_dma_arbiter u_dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cpu_cyc_i (cpu_cyc),
        .cpu_gnt_o (cpu_gnt),
        .dma_req_i (dma_req),
        .dma_cyc_i (dma_cyc),
        .dma_gnt_o (dma_gnt),
        .owner_o   (owner),
        .tmo_o     (tmo)
    );

    wb_dma_arbiter #(.NDMA(4), .CPU_SLOT(4), .TIMEOUT(8)) u_tmo (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cpu_cyc_i (1'b0),
        .cpu_gnt_o (t_cpu_gnt),
        .dma_req_i (t_req),
        .dma_cyc_i (t_cyc),
        .dma_gnt_o (t_gnt),
        .owner_o   (t_owner),
        .tmo_o     (t_tmo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant exclusivity on both instances, every cycle.
    always @(negedge clk) begin
        checks++;
        assert (!(cpu_gnt && |dma_gnt) && $onehot0(dma_gnt) &&
                !(t_cpu_gnt && |t_gnt) && $onehot0(t_gnt)) else begin
            errors++;
            $error("FAIL excl observed=%b/%b %b/%b expected=exclusive one-hot",
                   cpu_gnt, dma_gnt, t_cpu_gnt, t_gnt);
        end
    end

    // From a CPU-entry edge (slot_cnt=0) with a request pending on the
    // default instance: four CPU-granted cycles, then DRAIN.
    task automatic approach(input string tag);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk({tag, "_cpu"}, {cpu_gnt, dma_gnt}, {1'b1, 4'b0000});
        end
        tick();
        chk({tag, "_drain"}, {cpu_gnt, dma_gnt}, {1'b0, 4'b0000});
    endtask

    initial begin
        logic [3:0]  k_gnt;
        logic [10:0] cyc_pat;

        rst     = 1'b1;
        cpu_cyc = 1'b0;
        dma_req = 4'b0000;
        dma_cyc = 4'b0000;
        t_req   = 4'b0000;
        t_cyc   = 4'b0000;
        tick();
        tick();
        chk("reset", {cpu_gnt, dma_gnt, owner, tmo}, {1'b1, 4'b0000, 3'd0, 1'b0});

        // 1: idle bus stays with the CPU.
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle", {cpu_gnt, dma_gnt, owner}, {1'b1, 4'b0000, 3'd0});
        end

        // 2: slot already expired, request for master 1.
        dma_req = 4'b0010;
        tick();
        chk("lat_n1", {cpu_gnt, dma_gnt}, {1'b0, 4'b0000});
        tick();
        chk("lat_n2", {cpu_gnt, dma_gnt, owner}, {1'b0, 4'b0010, 3'd2});
        dma_cyc = 4'b0010;
        tick();
        chk("hold1", {dma_gnt, owner}, {4'b0010, 3'd2});
        dma_req = 4'b0000;
        dma_cyc = 4'b0000;
        tick();
        chk("dead1", {cpu_gnt, dma_gnt, owner, tmo}, {1'b0, 4'b0000, 3'd0, 1'b0});
        tick();
        chk("back_cpu1", {cpu_gnt, dma_gnt}, {1'b1, 4'b0000});

        // 3: CPU cycle in flight delays the grant until it ends.
        for (int i = 0; i < 5; i++) tick();
        cpu_cyc = 1'b1;
        dma_req = 4'b0001;
        tick();
        chk("drain_busy", {cpu_gnt, dma_gnt}, {1'b0, 4'b0000});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_wait", {cpu_gnt, dma_gnt}, {1'b0, 4'b0000});
        end
        cpu_cyc = 1'b0;
        tick();
        chk("drain_gnt", {dma_gnt, owner}, {4'b0001, 3'd1});
        dma_req = 4'b0000;
        tick();
        chk("dead3", dma_gnt, 4'b0000);
        tick();
        chk("back_cpu3", cpu_gnt, 1'b1);

        // 4: all four request; rotation 0,1,2,3,0 from a fresh rr_ptr.
        rst = 1'b1;
        tick();
        chk("reset4", {cpu_gnt, dma_gnt, owner}, {1'b1, 4'b0000, 3'd0});
        rst     = 1'b0;
        dma_req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            k_gnt = 4'b0001 << (r % 4);
            approach("rr");
            tick();
            chk("rr_gnt", {cpu_gnt, dma_gnt, owner}, {1'b0, k_gnt, 3'((r % 4) + 1)});
            dma_cyc = k_gnt;
            tick();
            tick();
            chk("rr_hold", dma_gnt, k_gnt);
            dma_req = dma_req & ~k_gnt;
            dma_cyc = 4'b0000;
            tick();
            chk("rr_dead", {cpu_gnt, dma_gnt}, {1'b0, 4'b0000});
            dma_req = 4'b1111;
            tick();
            chk("rr_cpu", {cpu_gnt, dma_gnt}, {1'b1, 4'b0000});
        end

        // 6: reset in the middle of master 2's tenure (rr_ptr is 1 here).
        dma_req = 4'b0100;
        approach("rst6");
        tick();
        chk("pre_rst_gnt", {dma_gnt, owner}, {4'b0100, 3'd3});
        dma_cyc = 4'b0100;
        rst     = 1'b1;
        tick();
        chk("mid_rst", {cpu_gnt, dma_gnt, owner, tmo}, {1'b1, 4'b0000, 3'd0, 1'b0});
        rst     = 1'b0;
        dma_req = 4'b0000;
        dma_cyc = 4'b0000;

        // 5: watchdog on the TIMEOUT=8 instance, freshly reset above.
        t_req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t_cpu", t_cpu_gnt, 1'b1);
        end
        tick();
        chk("t_drain", {t_cpu_gnt, t_gnt}, {1'b0, 4'b0000});
        tick();
        chk("t_gnt", {t_gnt, t_owner}, {4'b0001, 3'd1});
        // cyc per edge m=1..11 after the grant; busy at m=9,10 stalls the revoke to m=11.
        cyc_pat = 11'b01101010101;
        for (int m = 1; m <= 10; m++) begin
            t_cyc[0] = cyc_pat[m-1];
            tick();
            chk("t_hold", {t_gnt, t_tmo}, {4'b0001, 1'b0});
        end
        t_cyc[0] = cyc_pat[10];
        tick();
        chk("t_revoke", {t_gnt, t_owner, t_tmo}, {4'b0000, 3'd0, 1'b1});
        t_req = 4'b0011;
        tick();
        chk("t_pulse", {t_tmo, t_cpu_gnt}, {1'b0, 1'b1});
        for (int i = 0; i < 4; i++) tick();
        tick();
        chk("t_drain2", t_cpu_gnt, 1'b0);
        tick();
        chk("t_rr_after", {t_gnt, t_owner}, {4'b0010, 3'd2});
        chk("main_idle", {cpu_gnt, dma_gnt, tmo}, {1'b1, 4'b0000, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
